// File: rtl/hazard_scoreboard_ctrl.sv
// hazard_scoreboard_ctrl
// Issue/hazard controller sitting between DE and AGEX of the 5-stage RV32I
// pipeline. A per-register pending counter tracks in-flight writers; DE is
// stalled on RAW hazards, FE/DE are squashed on a taken AGEX redirect, and
// stall cycles are counted.
//
// Build option: define HAZARD_WB_BYPASS_EN to treat a source whose only
// pending writer is retiring in WB this cycle as ready (the register file
// writes before it is read), cutting a back-to-back RAW stall from 3 to 2.
module hazard_scoreboard_ctrl #(
    parameter int NUM_REGS     = 32,
    parameter int REG_IDX_BITS = 5,
    parameter int CNT_BITS     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    de_valid,
    input  logic [REG_IDX_BITS-1:0] de_rs1,
    input  logic                    de_rs1_used,
    input  logic [REG_IDX_BITS-1:0] de_rs2,
    input  logic                    de_rs2_used,
    input  logic [REG_IDX_BITS-1:0] de_rd,
    input  logic                    de_wr_reg,
    input  logic                    agex_br_taken,
    input  logic                    wb_valid,
    input  logic [REG_IDX_BITS-1:0] wb_rd,
    input  logic                    wb_wr_reg,
    output logic                    stall_fe,
    output logic                    stall_de,
    output logic                    bubble_agex,
    output logic                    flush_fe,
    output logic                    flush_de,
    output logic                    issue,
    output logic                    sb_err,
    output logic [31:0]             stall_cycles
);

    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

    // Pending-writer counters; entry 0 is held at zero so x0 is never busy.
    logic [CNT_BITS-1:0] pend_reg  [NUM_REGS];
    logic [CNT_BITS-1:0] pend_next [NUM_REGS];
    logic [NUM_REGS-1:0] ovf_hit;
    logic [NUM_REGS-1:0] unf_hit;

    logic        sb_err_reg;
    logic [31:0] stall_cycles_reg;

    logic inc;
    logic dec;
    logic rs1_busy;
    logic rs2_busy;
    logic haz;

    logic [CNT_BITS-1:0] pend_rs1;
    logic [CNT_BITS-1:0] pend_rs2;

    assign inc = issue & de_wr_reg & (de_rd != '0);
    assign dec = wb_valid & wb_wr_reg & (wb_rd != '0);

    assign pend_rs1 = pend_reg[de_rs1];
    assign pend_rs2 = pend_reg[de_rs2];

`ifdef HAZARD_WB_BYPASS_EN
    // A lone pending writer that is retiring right now is already visible
    // through the write-then-read register file, so it does not block.
    assign rs1_busy = de_rs1_used & (de_rs1 != '0) & (pend_rs1 != CNT_ZERO)
                    & ~((pend_rs1 == CNT_ONE) & dec & (wb_rd == de_rs1));
    assign rs2_busy = de_rs2_used & (de_rs2 != '0) & (pend_rs2 != CNT_ZERO)
                    & ~((pend_rs2 == CNT_ONE) & dec & (wb_rd == de_rs2));
`else
    assign rs1_busy = de_rs1_used & (de_rs1 != '0) & (pend_rs1 != CNT_ZERO);
    assign rs2_busy = de_rs2_used & (de_rs2 != '0) & (pend_rs2 != CNT_ZERO);
`endif

    assign haz = de_valid & (rs1_busy | rs2_busy);

    // Per-register next count: saturating increment on issue, floored
    // decrement on retire, and no change when both hit the same register.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if (gi == 0) begin : g_x0
                assign pend_next[gi] = CNT_ZERO;
                assign ovf_hit[gi]   = 1'b0;
                assign unf_hit[gi]   = 1'b0;
            end else begin : g_xn
                logic hit_inc;
                logic hit_dec;
                assign hit_inc = inc & (de_rd == REG_IDX_BITS'(gi));
                assign hit_dec = dec & (wb_rd == REG_IDX_BITS'(gi));
                assign ovf_hit[gi] = hit_inc & ~hit_dec & (pend_reg[gi] == CNT_MAX);
                assign unf_hit[gi] = hit_dec & ~hit_inc & (pend_reg[gi] == CNT_ZERO);
                assign pend_next[gi] =
                    (hit_inc & ~hit_dec & (pend_reg[gi] != CNT_MAX))  ? pend_reg[gi] + CNT_ONE :
                    (hit_dec & ~hit_inc & (pend_reg[gi] != CNT_ZERO)) ? pend_reg[gi] - CNT_ONE :
                                                                        pend_reg[gi];
            end
        end
    endgenerate

    // Scoreboard, sticky error flag and stall counter state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_reg[r] <= CNT_ZERO;
            end
            sb_err_reg       <= 1'b0;
            stall_cycles_reg <= 32'd0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                pend_reg[r] <= pend_next[r];
            end
            sb_err_reg       <= sb_err_reg | (|ovf_hit) | (|unf_hit);
            stall_cycles_reg <= stall_cycles_reg + 32'(stall_de);
        end
    end

    // Control outputs: redirect beats hazard; everything quiet during reset.
    always_comb begin
        stall_fe    = 1'b0;
        stall_de    = 1'b0;
        bubble_agex = 1'b0;
        flush_fe    = 1'b0;
        flush_de    = 1'b0;
        issue       = 1'b0;
        if (reset) begin
            if (agex_br_taken) begin
                flush_fe    = 1'b1;
                flush_de    = 1'b1;
                bubble_agex = 1'b1;
            end else if (haz) begin
                stall_fe    = 1'b1;
                stall_de    = 1'b1;
                bubble_agex = 1'b1;
            end else begin
                issue = de_valid;
            end
        end
    end

    assign sb_err       = sb_err_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: doc/hazard_scoreboard_ctrl.md
Name: hazard_scoreboard_ctrl

Overview:
- Issue/hazard controller between the DE and AGEX stages of the 5-stage RV32I pipeline.
- Tracks in-flight destination registers with a per-register pending counter, which forms the scoreboard.
- Stalls FE/DE on RAW hazards.
- Squashes wrong-path FE/DE instructions when AGEX resolves a taken branch or jump.
- Keeps a stall-cycle performance counter.

Parameters:
- NUM_REGS, 32, number of architectural registers.
- REG_IDX_BITS, 5, register index width.
- CNT_BITS, 2, pending-counter width; holds up to 3 writers in flight (AGEX/MEM/WB).

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-low reset; sampled on posedge clk.
- de_valid  in  1  DE latch holds a valid instruction.
- de_rs1  in  REG_IDX_BITS  source 1 index.
- de_rs1_used  in  1  instruction reads rs1.
- de_rs2  in  REG_IDX_BITS  source 2 index.
- de_rs2_used  in  1  instruction reads rs2.
- de_rd  in  REG_IDX_BITS  destination index.
- de_wr_reg  in  1  instruction writes rd.
- agex_br_taken  in  1  AGEX resolved a taken branch/JAL/JALR this cycle.
- wb_valid  in  1  WB stage retiring a valid instruction.
- wb_rd  in  REG_IDX_BITS  retiring destination.
- wb_wr_reg  in  1  retiring instruction writes rd.
- stall_fe  out  1  hold PC and FE latch.
- stall_de  out  1  hold DE latch.
- bubble_agex  out  1  load a NOP (zero) into the AGEX latch.
- flush_fe  out  1  invalidate the FE latch at the next edge.
- flush_de  out  1  invalidate the DE latch at the next edge.
- issue  out  1  the DE instruction advances into AGEX this cycle.
- sb_err  out  1  sticky scoreboard overflow/underflow flag.
- stall_cycles  out  32  count of cycles with stall_de=1.

Behaviour:
- State: pend[r], CNT_BITS wide, for r = 1..NUM_REGS-1. pend[0] is constant 0 and is never written.
- Reset (reset=0 at posedge):
  - all pend = 0, sb_err = 0, stall_cycles = 0.
  - While reset=0, all outputs except stall_cycles/sb_err are forced 0.
- Hazard, combinational, same cycle:
  - haz = de_valid & ((de_rs1_used & de_rs1≠0 & pend[de_rs1]≠0) | (de_rs2_used & de_rs2≠0 & pend[de_rs2]≠0)).
- Priority: redirect over hazard.
  - agex_br_taken=1: flush_fe = flush_de = bubble_agex = 1; stall_fe = stall_de = 0; issue = 0.
  - else haz=1: stall_fe = stall_de = bubble_agex = 1; issue = 0; flushes = 0.
  - else: issue = de_valid; all other control outputs = 0.
- Redirect flush lasts exactly one cycle. Instructions already in MEM/WB are older than the branch and are not touched, so their pend entries persist.
- Scoreboard update at posedge:
  - inc = issue & de_wr_reg & de_rd≠0
  - dec = wb_valid & wb_wr_reg & wb_rd≠0
  - inc and dec on the same register in one cycle: count unchanged.
  - Otherwise pend[de_rd]+1 and/or pend[wb_rd]-1 independently.
- Boundaries:
  - Increment at max (3) saturates and sets sb_err.
  - Decrement at 0 stays 0 and sets sb_err.
  - sb_err clears only on reset.
- Latency:
  - A dependent instruction stalls until the producer's WB cycle has completed, i.e. it issues the cycle after the WB cycle.
  - Back-to-back dependent ADDs therefore stall 3 cycles (producer occupies AGEX, MEM, WB).
- stall_cycles increments when stall_de=1, wraps at 2^32-1 → 0.
- The block never stalls on x0 sources and never tracks x0 writes.

Optional Feature:
- Macro: HAZARD_WB_BYPASS_EN.
- When defined: a source whose only pending writer is retiring this cycle (pend[rs]==1 & dec & wb_rd==rs) is not a hazard. The register file write-then-read makes the value visible, so a dependent ADD stalls 2 cycles instead of 3.
- When undefined: the behaviour is as specified above.

Test Plan:
- Reset: drive reset=0 for 2 cycles with random inputs → all pend 0, sb_err=0, stall_cycles=0, all control outputs 0.
- RAW: issue ADD x5 (rd=5, wr); next cycle DE reads rs1=5 → stall_de=1 for 3 cycles; issue=1 on the cycle after WB retires x5; stall_cycles=3.
- x0: issue rd=0, then read rs1=0 and rs2=0 → no stall; pend unchanged.
- Redirect over hazard: DE stalled on x7 while agex_br_taken=1 → flush_fe=flush_de=bubble_agex=1, stall_de=0, no pend increment; next cycle controls return to 0.
- Same-cycle inc/dec: pend[3]=1, issue rd=3 while WB retires rd=3 → pend[3] stays 1. WB retire of x9 with pend[9]=0 → sb_err=1 and stays set.
- With HAZARD_WB_BYPASS_EN: repeat the RAW scenario → stall_de=1 for exactly 2 cycles.
